// File: rtl/pool_bin.sv
// 2x2 stride-2 signed max-pool with threshold binarisation on the conv_mix result stream.
// Geometry is 12x12 -> 6x6 (state=0) or 4x4 -> 2x2 (state=1), latched at the first word of a frame.
module pool_bin #(
    parameter int DW   = 32,
    parameter int MAXW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          state,
    input  logic [DW-1:0] thr,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    input  logic          din_last,
    output logic [DW-1:0] dout_val,
    output logic          dout_bit,
    output logic          ovalid,
    output logic          done,
    output logic          err
);

    localparam int CW = $clog2(MAXW);

    // Handshake: din_valid qualifies din/din_last; there is no ready, every qualified
    // word is consumed in the cycle it arrives. ovalid/done are one-cycle pulses.
    typedef enum logic {IDLE, RUN} fsm_t;

    fsm_t                 fsm;
    logic                 mode;
    logic [CW-1:0]        row;
    logic [CW-1:0]        col;
    logic signed [DW-1:0] hold;
    logic signed [DW-1:0] linebuf [MAXW/2];

    logic                 mode_now;
    logic [CW-1:0]        w_last;
    logic signed [DW-1:0] din_s;
    logic signed [DW-1:0] thr_s;
    logic signed [DW-1:0] pmax;
    logic signed [DW-1:0] lb_rd;
    logic signed [DW-1:0] result;
    logic                 at_end;
    logic                 col_end;
    logic                 abort;
    logic                 is_out;
    logic                 lb_wr;

    always_comb begin
        // In IDLE the incoming word opens the frame, so its geometry comes straight from state.
        mode_now = (fsm == IDLE) ? state : mode;
        w_last   = mode_now ? CW'(3) : CW'(MAXW - 1);
        din_s    = din;
        thr_s    = thr;
        pmax     = (hold > din_s) ? hold : din_s;
        lb_rd    = linebuf[col[CW-1:1]];
        result   = (lb_rd > pmax) ? lb_rd : pmax;
        col_end  = (col == w_last);
        at_end   = col_end && (row == w_last);
        abort    = din_last && !at_end;
        is_out   = col[0] && row[0];
        lb_wr    = din_valid && !abort && col[0] && !row[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm      <= IDLE;
            mode     <= 1'b0;
            row      <= '0;
            col      <= '0;
            hold     <= '0;
            dout_val <= '0;
            dout_bit <= 1'b0;
            ovalid   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            ovalid <= 1'b0;
            done   <= 1'b0;
            if (din_valid) begin
                if (fsm == IDLE) begin
                    mode <= state;
                    fsm  <= RUN;
                end
                if (abort) begin
                    err <= 1'b1;
                    fsm <= IDLE;
                    row <= '0;
                    col <= '0;
                end else begin
                    if (!col[0]) begin
                        hold <= din_s;
                    end
                    if (is_out) begin
                        dout_val <= result;
                        dout_bit <= (result >= thr_s);
                        ovalid   <= 1'b1;
                    end
                    if (at_end) begin
                        done <= 1'b1;
                        fsm  <= IDLE;
                        row  <= '0;
                        col  <= '0;
                        if (!din_last) begin
                            err <= 1'b1;
                        end
                    end else if (col_end) begin
                        col <= '0;
                        row <= row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
            end
        end
    end

    // Pair maxima of even rows wait here for the matching pair of the following odd row.
    always_ff @(posedge clk) begin
        if (!rst && lb_wr) begin
            linebuf[col[CW-1:1]] <= pmax;
        end
    end

endmodule
